// File: rtl/led_pattern_gen.sv
// rtl/led_pattern_gen.sv - LED pattern generator: walking dot, ping-pong dot and fill/empty bar
module led_pattern_gen #(
  parameter int WIDTH = 8,
  parameter int DIV_W = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [DIV_W-1:0] div,
  output logic [WIDTH-1:0] LED,
  output logic             tick,
  output logic             wrap
);

  typedef enum logic {DIR_RIGHT, DIR_LEFT} dir_e;
  typedef enum logic {PH_FILL, PH_EMPTY} phase_e;

  localparam logic [WIDTH-1:0] LEFT_DOT  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] RIGHT_DOT = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]       mode_q, mode_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] led_q, led_d;
  dir_e             dir_q, dir_d;
  phase_e           phase_q, phase_d;
  logic             tick_q, tick_d;
  logic             wrap_q, wrap_d;

  logic [WIDTH-1:0] step_led;
  dir_e             step_dir;
  phase_e           step_phase;
  logic             step_wrap;
  logic             one_hot;

  function automatic logic [WIDTH-1:0] start_val(input logic [1:0] m);
    case (m)
      2'b01:   return RIGHT_DOT;
      2'b11:   return '0;
      default: return LEFT_DOT;
    endcase
  endfunction

  // Next pattern value assuming a step is taken this edge.
  always_comb begin
    step_led   = led_q;
    step_dir   = dir_q;
    step_phase = phase_q;
    step_wrap  = 1'b0;
    one_hot    = (led_q != '0) && ((led_q & (led_q - RIGHT_DOT)) == '0);
    case (mode_q)
      2'b00: begin
        if (!one_hot) begin
          step_led = LEFT_DOT;
        end else begin
          step_led  = {led_q[0], led_q[WIDTH-1:1]};
          step_wrap = led_q[0];
        end
      end
      2'b01: begin
        if (!one_hot) begin
          step_led = RIGHT_DOT;
        end else begin
          step_led  = {led_q[WIDTH-2:0], led_q[WIDTH-1]};
          step_wrap = led_q[WIDTH-1];
        end
      end
      2'b10: begin
        if (!one_hot) begin
          step_led = LEFT_DOT;
          step_dir = DIR_RIGHT;
        end else if (dir_q == DIR_RIGHT) begin
          step_led = led_q >> 1;
          if (led_q[1]) step_dir = DIR_LEFT;
        end else begin
          step_led = led_q << 1;
          if (led_q[WIDTH-2]) begin
            step_dir  = DIR_RIGHT;
            step_wrap = 1'b1;
          end
        end
      end
      default: begin
        if (phase_q == PH_FILL) begin
          step_led = {1'b1, led_q[WIDTH-1:1]};
          if (&led_q[WIDTH-1:1]) step_phase = PH_EMPTY;
        end else begin
          step_led = {1'b0, led_q[WIDTH-1:1]};
          if (led_q[WIDTH-1:1] == '0) begin
            step_phase = PH_FILL;
            step_wrap  = 1'b1;
          end
        end
      end
    endcase
  end

  // A mode change restarts the pattern regardless of en; cnt >= div also covers div lowered mid-count.
  always_comb begin
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    led_d   = led_q;
    dir_d   = dir_q;
    phase_d = phase_q;
    tick_d  = 1'b0;
    wrap_d  = 1'b0;
    if (mode != mode_q) begin
      mode_d  = mode;
      led_d   = start_val(mode);
      cnt_d   = '0;
      dir_d   = DIR_RIGHT;
      phase_d = PH_FILL;
    end else if (en) begin
      if (cnt_q >= div) begin
        cnt_d   = '0;
        led_d   = step_led;
        dir_d   = step_dir;
        phase_d = step_phase;
        tick_d  = 1'b1;
        wrap_d  = step_wrap;
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      mode_q  <= mode;
      cnt_q   <= '0;
      led_q   <= start_val(mode);
      dir_q   <= DIR_RIGHT;
      phase_q <= PH_FILL;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      led_q   <= led_d;
      dir_q   <= dir_d;
      phase_q <= phase_d;
      tick_q  <= tick_d;
      wrap_q  <= wrap_d;
    end
  end

  assign LED  = led_q;
  assign tick = tick_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// tb/tb_led_pattern_gen.sv - randomized self-checking bench for led_pattern_gen
module tb_led_pattern_gen;

  localparam int W  = 8;
  localparam int DW = 24;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          en;
  logic [1:0]    mode_i;
  logic [DW-1:0] div_i;
  logic [W-1:0]  led;
  logic          tick;
  logic          wrap;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: pattern position as a step index within the mode's period.
  int m_mode = 0;
  int m_k    = 0;
  int m_cnt  = 0;
  bit m_tick = 1'b0;
  bit m_wrap = 1'b0;

  led_pattern_gen #(.WIDTH(W), .DIV_W(DW)) dut (
    .clk  (clk),
    .reset(reset_n),
    .en   (en),
    .mode (mode_i),
    .div  (div_i),
    .LED  (led),
    .tick (tick),
    .wrap (wrap)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int period(input int m);
    if (m == 2) return 2 * (W - 1);
    if (m == 3) return 2 * W;
    return W;
  endfunction

  function automatic logic [31:0] pat(input int m, input int k);
    int r;
    case (m)
      0:       r = 1 << (W - 1 - k);
      1:       r = 1 << k;
      2:       r = (k <= W - 1) ? (1 << (W - 1 - k)) : (1 << (k - (W - 1)));
      default: r = (k <= W) ? (((1 << k) - 1) << (W - k)) : ((1 << (2 * W - k)) - 1);
    endcase
    return r & ((1 << W) - 1);
  endfunction

  task automatic cyc();
    @(posedge clk);
    if (!reset_n || int'(mode_i) != m_mode) begin
      m_mode = int'(mode_i);
      m_k    = 0;
      m_cnt  = 0;
      m_tick = 1'b0;
      m_wrap = 1'b0;
    end else if (en) begin
      if (m_cnt >= int'(div_i)) begin
        m_cnt  = 0;
        m_k    = (m_k + 1) % period(m_mode);
        m_tick = 1'b1;
        m_wrap = (m_k == 0);
      end else begin
        m_cnt++;
        m_tick = 1'b0;
        m_wrap = 1'b0;
      end
    end else begin
      m_tick = 1'b0;
      m_wrap = 1'b0;
    end
    #1;
    check("led", 32'(led), pat(m_mode, m_k));
    check("tick", 32'(tick), 32'(m_tick));
    check("wrap", 32'(wrap), 32'(m_wrap));
    check("wrap_needs_tick", 32'(wrap & ~tick), 32'd0);
  endtask

  initial begin
    reset_n = 1'b0;
    en      = 1'b1;
    mode_i  = 2'b00;
    div_i   = '0;
    cyc();
    cyc();
    check("rst_led", 32'(led), 32'h80);
    check("rst_tick", 32'(tick), 32'd0);
    reset_n = 1'b1;
    repeat (20) cyc();

    mode_i = 2'b10;
    div_i  = 3;
    repeat (70) cyc();

    mode_i = 2'b11;
    div_i  = 0;
    repeat (40) cyc();

    mode_i = 2'b00;
    div_i  = 4;
    repeat (7) cyc();
    en = 1'b0;
    repeat (7) cyc();
    en = 1'b1;
    repeat (30) cyc();

    div_i = 0;
    for (int i = 0; i < 16 && led !== 8'h10; i++) cyc();
    check("reach_10", 32'(led), 32'h10);
    mode_i = 2'b01;
    cyc();
    check("sw_led", 32'(led), 32'h01);
    check("sw_tick", 32'(tick), 32'd0);
    check("sw_wrap", 32'(wrap), 32'd0);
    repeat (10) cyc();

    mode_i = 2'b10;
    cyc();
    repeat (10) cyc();
    reset_n = 1'b0;
    cyc();
    check("rst_mid_led", 32'(led), 32'h80);
    check("rst_mid_tick", 32'(tick), 32'd0);
    reset_n = 1'b1;
    div_i   = 2;
    repeat (12) cyc();

    div_i = 20;
    repeat (10) cyc();
    div_i = 3;
    repeat (10) cyc();

    for (int i = 0; i < 3000; i++) begin
      reset_n = ($urandom_range(0, 99) != 0);
      en      = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 39) == 0) mode_i = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 49) == 0) div_i = DW'($urandom_range(0, 5));
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
